// File: rtl/tlc_request_conditioner.sv
// Synchronises/debounces the pedestrian button and loop sensor into a latched ped_request and a qualified traffic_request.
// Define TLC_WAIT_BLINK_EN to blink ped_wait_lamp while a request is pending.
module tlc_request_conditioner #(
  parameter int SYNC_STAGES      = 2,
  parameter int DEBOUNCE_CYCLES  = 50000,
  parameter int OCCUPANCY_CYCLES = 2000,
  parameter int BLINK_CYCLES     = 25000
) (
  input  logic clk,
  input  logic reset,
  input  logic ped_button_raw,
  input  logic sensor_raw,
  input  logic ped_served,
  output logic ped_request,
  output logic traffic_request,
  output logic ped_wait_lamp
);

  localparam logic [15:0] DEB_LIM = 16'(DEBOUNCE_CYCLES);
  localparam logic [15:0] OCC_LIM = 16'(OCCUPANCY_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_SERVING} ped_state_t;

  logic [SYNC_STAGES-1:0] btn_sync_q, btn_sync_d;
  logic [SYNC_STAGES-1:0] sen_sync_q, sen_sync_d;
  logic                   btn_deb_q, btn_deb_d;
  logic                   sen_deb_q, sen_deb_d;
  logic [15:0]            btn_cnt_q, btn_cnt_d;
  logic [15:0]            sen_cnt_q, sen_cnt_d;
  logic                   btn_prev_q, btn_prev_d;
  logic [15:0]            occ_q, occ_d;
  ped_state_t             state_q, state_d;
  logic                   ped_request_q, ped_request_d;
  logic                   traffic_request_q, traffic_request_d;
  logic                   ped_wait_lamp_q, ped_wait_lamp_d;
  logic                   btn_rise;

  always_comb begin
    btn_sync_d = {btn_sync_q[SYNC_STAGES-2:0], ped_button_raw};
    sen_sync_d = {sen_sync_q[SYNC_STAGES-2:0], sensor_raw};
  end

  // Any agreeing sample clears the counter, so a bounce restarts qualification.
  always_comb begin
    btn_deb_d = btn_deb_q;
    btn_cnt_d = '0;
    if (btn_sync_q[SYNC_STAGES-1] != btn_deb_q) begin
      if (btn_cnt_q + 16'd1 == DEB_LIM) btn_deb_d = ~btn_deb_q;
      else                              btn_cnt_d = btn_cnt_q + 16'd1;
    end
    sen_deb_d = sen_deb_q;
    sen_cnt_d = '0;
    if (sen_sync_q[SYNC_STAGES-1] != sen_deb_q) begin
      if (sen_cnt_q + 16'd1 == DEB_LIM) sen_deb_d = ~sen_deb_q;
      else                              sen_cnt_d = sen_cnt_q + 16'd1;
    end
  end

  always_comb begin
    btn_prev_d        = btn_deb_q;
    btn_rise          = btn_deb_q & ~btn_prev_q;
    occ_d             = '0;
    if (sen_deb_q) occ_d = (occ_q == OCC_LIM) ? occ_q : occ_q + 16'd1;
    traffic_request_d = (occ_q == OCC_LIM);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (btn_rise)    state_d = ST_PENDING;
      ST_PENDING: if (ped_served)  state_d = ST_SERVING;
      ST_SERVING: if (!ped_served) state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
    ped_request_d = (state_q == ST_PENDING);
  end

`ifdef TLC_WAIT_BLINK_EN
  localparam logic [15:0] BLINK_LIM = 16'(BLINK_CYCLES);
  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic        blink_ph_q, blink_ph_d;

  // Phase starts at 0 (lamp on) on every entry to PENDING.
  always_comb begin
    blink_cnt_d = '0;
    blink_ph_d  = 1'b0;
    if (state_q == ST_PENDING) begin
      if (blink_cnt_q + 16'd1 == BLINK_LIM) begin
        blink_ph_d = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
        blink_ph_d  = blink_ph_q;
      end
    end
    ped_wait_lamp_d = (state_q == ST_PENDING) & ~blink_ph_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
    end
  end
`else
  logic unused_blink_cycles;
  assign unused_blink_cycles = ^BLINK_CYCLES;

  always_comb ped_wait_lamp_d = (state_q == ST_PENDING);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_sync_q        <= '0;
      sen_sync_q        <= '0;
      btn_deb_q         <= 1'b0;
      sen_deb_q         <= 1'b0;
      btn_cnt_q         <= '0;
      sen_cnt_q         <= '0;
      btn_prev_q        <= 1'b0;
      occ_q             <= '0;
      state_q           <= ST_IDLE;
      ped_request_q     <= 1'b0;
      traffic_request_q <= 1'b0;
      ped_wait_lamp_q   <= 1'b0;
    end else begin
      btn_sync_q        <= btn_sync_d;
      sen_sync_q        <= sen_sync_d;
      btn_deb_q         <= btn_deb_d;
      sen_deb_q         <= sen_deb_d;
      btn_cnt_q         <= btn_cnt_d;
      sen_cnt_q         <= sen_cnt_d;
      btn_prev_q        <= btn_prev_d;
      occ_q             <= occ_d;
      state_q           <= state_d;
      ped_request_q     <= ped_request_d;
      traffic_request_q <= traffic_request_d;
      ped_wait_lamp_q   <= ped_wait_lamp_d;
    end
  end

  assign ped_request     = ped_request_q;
  assign traffic_request = traffic_request_q;
  assign ped_wait_lamp   = ped_wait_lamp_q;

endmodule

// File: tb/tb_tlc_request_conditioner.sv
// Randomized bench for tlc_request_conditioner against a history-based reference model.
module tb_tlc_request_conditioner;

  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int OCC   = 8;
  localparam int BLINK = 3;
  localparam int MAXN  = 8192;
  localparam int M_IDLE = 0, M_PEND = 1, M_SERV = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn = 1'b0, sen = 1'b0, srv = 1'b0;
  logic ped_request, traffic_request, ped_wait_lamp;

  int n_tests = 0;
  int n_fail  = 0;

  tlc_request_conditioner #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
    .OCCUPANCY_CYCLES(OCC), .BLINK_CYCLES(BLINK)
  ) dut (
    .clk(clk), .reset(reset),
    .ped_button_raw(btn), .sensor_raw(sen), .ped_served(srv),
    .ped_request(ped_request), .traffic_request(traffic_request),
    .ped_wait_lamp(ped_wait_lamp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: per-edge histories since the last reset release.
  bit rb [MAXN];
  bit rs [MAXN];
  bit db [MAXN];
  bit ds [MAXN];
  int st [MAXN];
  int n = 0;
  logic exp_req = 1'b0, exp_trf = 1'b0, exp_lamp = 1'b0;

  function automatic bit g_rb(int i); return (i < 0) ? 1'b0 : rb[i]; endfunction
  function automatic bit g_rs(int i); return (i < 0) ? 1'b0 : rs[i]; endfunction
  function automatic bit g_db(int i); return (i < 0) ? 1'b0 : db[i]; endfunction
  function automatic bit g_ds(int i); return (i < 0) ? 1'b0 : ds[i]; endfunction
  function automatic int g_st(int i); return (i < 0) ? M_IDLE : st[i]; endfunction

  task automatic model_reset();
    for (int i = 0; i < MAXN; i++) begin
      rb[i] = 0; rs[i] = 0; db[i] = 0; ds[i] = 0; st[i] = M_IDLE;
    end
    n = 0;
    exp_req = 0; exp_trf = 0; exp_lamp = 0;
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      bit pb, ps, fb, fs, rise;
      int pst, nst, run, k;
      rb[n] = btn;
      rs[n] = sen;
      // A debounced value flips once the last DEB synchronised samples all disagree with it.
      pb = g_db(n-1); ps = g_ds(n-1); fb = 1; fs = 1;
      for (int j = 0; j < DEB; j++) begin
        if (g_rb(n-SYNC-j) == pb) fb = 0;
        if (g_rs(n-SYNC-j) == ps) fs = 0;
      end
      db[n] = fb ? !pb : pb;
      ds[n] = fs ? !ps : ps;
      pst  = g_st(n-1);
      rise = g_db(n-1) && !g_db(n-2);
      nst  = pst;
      if (pst == M_IDLE && rise) nst = M_PEND;
      else if (pst == M_PEND && srv) nst = M_SERV;
      else if (pst == M_SERV && !srv) nst = M_IDLE;
      st[n] = nst;
      exp_req = (pst == M_PEND);
      run = 0;
      for (int i = n-2; i >= 0 && ds[i] && run < OCC; i--) run++;
      exp_trf = (run >= OCC);
`ifdef TLC_WAIT_BLINK_EN
      k = 0;
      while (g_st(n-2-k) == M_PEND) k++;
      exp_lamp = (pst == M_PEND) && (((k / BLINK) % 2) == 0);
`else
      k = 0;
      exp_lamp = exp_req;
`endif
      n++;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("ped_request", ped_request, exp_req);
      check("traffic_request", traffic_request, exp_trf);
      check("ped_wait_lamp", ped_wait_lamp, exp_lamp);
    end
  end

  int btn_left = 0, sen_left = 0, srv_left = 0;

  task automatic drive_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (btn_left == 0) begin btn = 1'($urandom_range(0, 1)); btn_left = $urandom_range(1, 12); end
      if (sen_left == 0) begin sen = 1'($urandom_range(0, 1)); sen_left = $urandom_range(1, 20); end
      if (srv_left == 0) begin srv = 1'($urandom_range(0, 1)); srv_left = $urandom_range(1, 15); end
      btn_left--; sen_left--; srv_left--;
    end
  endtask

  task automatic hold(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    int edges;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_ped_request", ped_request, 0);
    check("reset_traffic_request", traffic_request, 0);
    check("reset_ped_wait_lamp", ped_wait_lamp, 0);
    @(negedge clk);
    reset = 1'b0;
    hold(3);

    // Clean press latency
    btn = 1'b1;
    edges = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ped_request) break;
      edges++;
    end
    check("ped_request_latency", edges, 7);
    hold(20);
    btn = 1'b0;
    hold(10);

    // Occupancy rise and fall latency
    sen = 1'b1;
    edges = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (traffic_request) break;
      edges++;
    end
    check("traffic_rise_latency", edges, 14);
    @(negedge clk);
    sen = 1'b0;
    edges = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (!traffic_request) break;
      edges++;
    end
    check("traffic_fall_latency", edges, 7);

    // Short sensor pulse and service handshake with a press during service
    @(negedge clk);
    sen = 1'b1; hold(5); sen = 1'b0;
    srv = 1'b1; hold(3); btn = 1'b1; hold(7); srv = 1'b0; btn = 1'b0; hold(10);
    btn = 1'b1; hold(15); btn = 1'b0; hold(5);

    drive_random(2000);

    // Asynchronous reset while a request is pending and traffic is qualified
    @(negedge clk);
    btn = 1'b0; srv = 1'b0; sen = 1'b1;
    hold(10);
    btn = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (ped_request && traffic_request) break;
    end
    check("pending_and_traffic_reached", {ped_request, traffic_request}, 2'b11);
    @(posedge clk); #3;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_reset_ped_request", ped_request, 0);
    check("async_reset_traffic_request", traffic_request, 0);
    check("async_reset_ped_wait_lamp", ped_wait_lamp, 0);
    @(negedge clk);
    btn = 1'b0; sen = 1'b0;
    hold(2);
    reset = 1'b0;
    btn_left = 0; sen_left = 0; srv_left = 0;
    hold(20);

    drive_random(1500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
